ifu_fetch_queue: RTL

// Instruction fetch unit with a prefetch queue. Sits directly upstream of the decode stage (controller/splitter).

---
 rtl/ifu_fetch_queue_pkg.sv | 23 ++
 rtl/ifu_fetch_queue_fifo.sv | 57 +++++
 rtl/ifu_fetch_queue.sv | 133 +++++++++++++
 3 files changed

// File: rtl/ifu_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
package ifu_fetch_queue_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_3000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  // Sequential word address; wraps modulo 2^XLEN.
  function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/ifu_fetch_queue_fifo.sv
// Prefetch FIFO of {pc, inst} entries; flush wins over write and read.
module ifu_fetch_queue_fifo
  import ifu_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         wr_en,
  input  fetch_entry_t                 wr_data,
  input  logic                         rd_en,
  output fetch_entry_t                 rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             rd_fire;
  logic             wr_fire;

  // Reads of an empty FIFO are ignored; a write to a full FIFO only lands alongside a read.
  assign rd_fire = rd_en && (count != '0);
  assign wr_fire = wr_en && ((count != CNT_W'(DEPTH)) || rd_fire);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_fire && !flush) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_fire) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_fire, rd_fire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ifu_fetch_queue.sv
// Instruction fetch unit: owns the fetch PC, issues one imem request at a time
// and buffers returned words with their PC for the decode stage.
module ifu_fetch_queue
  import ifu_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        imem_req,
  output logic [31:0]                 imem_addr,
  input  logic                        imem_ack,
  input  logic [31:0]                 imem_rdata,
  input  logic                        redirect,
  input  logic [31:0]                 redirect_pc,
  input  logic                        deq,
  output logic                        inst_valid,
  output logic [31:0]                 inst,
  output logic [31:0]                 inst_pc,
  output logic [31:0]                 inst_pc4,
  output logic [$clog2(DEPTH+1)-1:0]  level
);

  localparam int unsigned CNT_W  = $clog2(DEPTH+1);
  localparam int unsigned CNT_W1 = CNT_W + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          req_d;
  logic [31:0]   addr_d;
  logic          enq;
  logic          flush;
  logic          deq_eff;
  logic [31:0]   target_pc;
  logic [CNT_W-1:0]  count;
  logic [CNT_W1-1:0] cnt_next;
  fetch_entry_t  enq_data;
  fetch_entry_t  head;

  assign target_pc = redirect_pc & ~32'h3;
  assign deq_eff   = deq && (count != '0);
  // Occupancy after this cycle's enqueue/dequeue, used as the credit for back-to-back issue.
  assign cnt_next  = CNT_W1'(count) + CNT_W1'(1) - CNT_W1'(deq_eff);
  assign enq_data  = '{pc: imem_addr, inst: imem_rdata};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_d      = imem_req;
    addr_d     = imem_addr;
    enq        = 1'b0;
    flush      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (redirect) begin
          flush      = 1'b1;
          fetch_pc_d = target_pc;
        end else if (count < CNT_W'(DEPTH)) begin
          req_d      = 1'b1;
          addr_d     = fetch_pc_q;
          fetch_pc_d = pc_inc(fetch_pc_q);
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect) begin
          flush      = 1'b1;
          fetch_pc_d = target_pc;
          if (imem_ack) begin
            req_d   = 1'b0;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DROP;
          end
        end else if (imem_ack) begin
          enq = 1'b1;
          if (cnt_next < CNT_W1'(DEPTH)) begin
            addr_d     = fetch_pc_q;
            fetch_pc_d = pc_inc(fetch_pc_q);
          end else begin
            req_d   = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
      ST_DROP: begin
        // Stale request still in flight: keep it up until acked, then discard its data.
        if (redirect) fetch_pc_d = target_pc;
        if (imem_ack) begin
          req_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      imem_req   <= 1'b0;
      imem_addr  <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      imem_req   <= req_d;
      imem_addr  <= addr_d;
    end
  end

  ifu_fetch_queue_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .flush   (flush),
    .wr_en   (enq),
    .wr_data (enq_data),
    .rd_en   (deq),
    .rd_data (head),
    .count   (count)
  );

  assign inst_valid = (count != '0);
  assign inst       = head.inst;
  assign inst_pc    = head.pc;
  assign inst_pc4   = pc_inc(head.pc);
  assign level      = count;

endmodule
